// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only bundle between the system-ID checker (master) and the sysid slave.
interface sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM after reset or on request,
// and reports whether they match the build-time expectations.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0400_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1415959147,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  sysid_checker_if.master avm,
  output logic            busy,
  output logic            done,
  output logic            id_ok,
  output logic            timeout,
  output logic [31:0]     sys_id,
  output logic [31:0]     sys_ts
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FIN} state_e;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        read_q, read_d;
  logic [15:0] waitCnt_q, waitCnt_d;
  logic        autoPend_q, autoPend_d;
  logic        done_q, done_d;
  logic        idOk_q, idOk_d;
  logic        timeout_q, timeout_d;
  logic [31:0] sysId_q, sysId_d;
  logic [31:0] sysTs_q, sysTs_d;

  logic launch;
  logic accept;
  logic stall;
  logic expire;
  logic idMatch;
  logic tsMatch;

  assign launch  = autoPend_q || start;
  assign accept  = read_q && !avm.avm_waitrequest;
  assign stall   = read_q && avm.avm_waitrequest;
  assign expire  = stall && (waitCnt_q == TIMEOUT_LAST);
  assign idMatch = (sysId_q == EXPECTED_ID);
  assign tsMatch = !CHECK_TS || (sysTs_q == EXPECTED_TS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = RD_ID;
      RD_ID: begin
        if (accept) begin
          state_d = RD_TS;
        end else if (expire) begin
          state_d = FIN;
        end
      end
      RD_TS:   if (accept || expire) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy            = (state_q != IDLE);
    avm.avm_address = (state_q == RD_TS);
    avm.avm_read    = read_q;
  end

  // The strobe is registered so the first RD_TS cycle is an idle gap after the ID acceptance.
  always_comb begin
    read_d     = read_q;
    waitCnt_d  = waitCnt_q;
    autoPend_d = autoPend_q;
    done_d     = done_q;
    idOk_d     = idOk_q;
    timeout_d  = timeout_q;
    sysId_d    = sysId_q;
    sysTs_d    = sysTs_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          autoPend_d = 1'b0;
          read_d     = 1'b1;
          waitCnt_d  = 16'd0;
          done_d     = 1'b0;
          idOk_d     = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      RD_ID: begin
        if (accept) begin
          sysId_d   = avm.avm_readdata;
          read_d    = 1'b0;
          waitCnt_d = 16'd0;
        end else if (expire) begin
          read_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (stall) begin
          waitCnt_d = waitCnt_q + 16'd1;
        end
      end
      RD_TS: begin
        if (!read_q) begin
          read_d = 1'b1;
        end else if (accept) begin
          sysTs_d = avm.avm_readdata;
          read_d  = 1'b0;
        end else if (expire) begin
          read_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (stall) begin
          waitCnt_d = waitCnt_q + 16'd1;
        end
      end
      FIN: begin
        read_d = 1'b0;
        done_d = 1'b1;
        idOk_d = idMatch && tsMatch && !timeout_q;
      end
      default: read_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_q     <= 1'b0;
      waitCnt_q  <= 16'd0;
      autoPend_q <= 1'b1;
      done_q     <= 1'b0;
      idOk_q     <= 1'b0;
      timeout_q  <= 1'b0;
      sysId_q    <= 32'd0;
      sysTs_q    <= 32'd0;
    end else begin
      read_q     <= read_d;
      waitCnt_q  <= waitCnt_d;
      autoPend_q <= autoPend_d;
      done_q     <= done_d;
      idOk_q     <= idOk_d;
      timeout_q  <= timeout_d;
      sysId_q    <= sysId_d;
      sysTs_q    <= sysTs_d;
    end
  end

  assign done    = done_q;
  assign id_ok   = idOk_q;
  assign timeout = timeout_q;
  assign sys_id  = sysId_q;
  assign sys_ts  = sysTs_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: two instances (default, and CHECK_TS=0 with TIMEOUT_CYCLES=8)
// driven by behavioural stalling slaves and compared against a transaction-level model.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0400_0000;
  localparam logic [31:0] EXP_TS = 32'd1415959147;
  localparam int          TO_A   = 1023;
  localparam int          TO_B   = 8;

  logic clock;
  logic reset;
  logic start;

  sysid_checker_if ifA ();
  sysid_checker_if ifB ();

  logic        busyA, doneA, idOkA, toA;
  logic [31:0] sysIdA, sysTsA;
  logic        busyB, doneB, idOkB, toB;
  logic [31:0] sysIdB, sysTsB;

  logic [31:0] idWordA, tsWordA, idWordB, tsWordB;
  int          stallIdA, stallTsA, stallIdB, stallTsB;
  int          stallCntA, stallCntB;

  bit          acceptsA[$];
  bit          acceptsB[$];
  bit          prevStallA, prevAcceptA, prevAddrA;
  bit          prevStallB, prevAcceptB, prevAddrB;

  logic [31:0] expIdA, expTsA, expIdB, expTsB;
  bit          expOkA, expToA, expOkB, expToB;
  int          expReadsA, expReadsB;

  int assertCount;
  int failCount;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  sysid_checker dutA (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .avm     (ifA),
    .busy    (busyA),
    .done    (doneA),
    .id_ok   (idOkA),
    .timeout (toA),
    .sys_id  (sysIdA),
    .sys_ts  (sysTsA)
  );

  sysid_checker #(.CHECK_TS(1'b0), .TIMEOUT_CYCLES(TO_B)) dutB (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .avm     (ifB),
    .busy    (busyB),
    .done    (doneB),
    .id_ok   (idOkB),
    .timeout (toB),
    .sys_id  (sysIdB),
    .sys_ts  (sysTsB)
  );

  // Each slave stalls a read for a configured number of cycles, then accepts it.
  assign ifA.avm_waitrequest = ifA.avm_read && (stallCntA < (ifA.avm_address ? stallTsA : stallIdA));
  assign ifA.avm_readdata    = ifA.avm_address ? tsWordA : idWordA;
  assign ifB.avm_waitrequest = ifB.avm_read && (stallCntB < (ifB.avm_address ? stallTsB : stallIdB));
  assign ifB.avm_readdata    = ifB.avm_address ? tsWordB : idWordB;

  always @(posedge clock) begin
    stallCntA <= (ifA.avm_read && ifA.avm_waitrequest) ? stallCntA + 1 : 0;
    stallCntB <= (ifB.avm_read && ifB.avm_waitrequest) ? stallCntB + 1 : 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (prevStallA && stallCntA < TO_A) begin
        checkOutput("holdReadA", 32'(ifA.avm_read), 32'd1);
        checkOutput("holdAddrA", 32'(ifA.avm_address), 32'(prevAddrA));
      end
      if (prevAcceptA) checkOutput("gapA", 32'(ifA.avm_read), 32'd0);
      if (ifA.avm_read && !ifA.avm_waitrequest) acceptsA.push_back(ifA.avm_address);
      if (prevStallB && stallCntB < TO_B) begin
        checkOutput("holdReadB", 32'(ifB.avm_read), 32'd1);
        checkOutput("holdAddrB", 32'(ifB.avm_address), 32'(prevAddrB));
      end
      if (prevAcceptB) checkOutput("gapB", 32'(ifB.avm_read), 32'd0);
      if (ifB.avm_read && !ifB.avm_waitrequest) acceptsB.push_back(ifB.avm_address);
    end
    prevStallA  <= !reset && ifA.avm_read && ifA.avm_waitrequest;
    prevAcceptA <= !reset && ifA.avm_read && !ifA.avm_waitrequest;
    prevAddrA   <= ifA.avm_address;
    prevStallB  <= !reset && ifB.avm_read && ifB.avm_waitrequest;
    prevAcceptB <= !reset && ifB.avm_read && !ifB.avm_waitrequest;
    prevAddrB   <= ifB.avm_address;
  end

  // Transaction-level outcome of one check: a read times out once it is stalled `to` times.
  task automatic predict(input bit checkTs, input int to, input logic [31:0] idw, input logic [31:0] tsw,
                         input int sId, input int sTs, inout logic [31:0] eId, inout logic [31:0] eTs,
                         output bit eOk, output bit eTo, output int eReads);
    eTo    = 1'b0;
    eReads = 0;
    if (sId >= to) begin
      eTo = 1'b1;
    end else begin
      eId    = idw;
      eReads = 1;
      if (sTs >= to) begin
        eTo = 1'b1;
      end else begin
        eTs    = tsw;
        eReads = 2;
      end
    end
    eOk = !eTo && (idw == EXP_ID) && (!checkTs || tsw == EXP_TS);
  endtask

  task automatic applyStimulus(input bit viaReset,
                               input logic [31:0] iA, input logic [31:0] tA, input int siA, input int stA,
                               input logic [31:0] iB, input logic [31:0] tB, input int siB, input int stB);
    idWordA  = iA;  tsWordA  = tA;  stallIdA = siA; stallTsA = stA;
    idWordB  = iB;  tsWordB  = tB;  stallIdB = siB; stallTsB = stB;
    if (viaReset) begin
      expIdA = 32'd0; expTsA = 32'd0; expIdB = 32'd0; expTsB = 32'd0;
    end
    predict(1'b1, TO_A, iA, tA, siA, stA, expIdA, expTsA, expOkA, expToA, expReadsA);
    predict(1'b0, TO_B, iB, tB, siB, stB, expIdB, expTsB, expOkB, expToB, expReadsB);
    acceptsA.delete();
    acceptsB.delete();
    if (viaReset) begin
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock);
      @(posedge clock); #1 reset = 1'b0;
    end else begin
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
    end
  endtask

  task automatic waitDone(output int latA);
    latA = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (doneA && latA < 0) latA = i;
      if (doneA && doneB) break;
    end
    checkOutput("doneReached", 32'({doneA, doneB}), 32'd3);
  endtask

  task automatic verifyAll(input string tag);
    checkOutput({tag, ":doneA"},  32'(doneA), 32'd1);
    checkOutput({tag, ":busyA"},  32'(busyA), 32'd0);
    checkOutput({tag, ":idOkA"},  32'(idOkA), 32'(expOkA));
    checkOutput({tag, ":toA"},    32'(toA),   32'(expToA));
    checkOutput({tag, ":sysIdA"}, sysIdA, expIdA);
    checkOutput({tag, ":sysTsA"}, sysTsA, expTsA);
    checkOutput({tag, ":readsA"}, 32'(acceptsA.size()), 32'(expReadsA));
    for (int i = 0; i < acceptsA.size() && i < 2; i++)
      checkOutput({tag, ":addrA"}, 32'(acceptsA[i]), 32'(i));
    checkOutput({tag, ":doneB"},  32'(doneB), 32'd1);
    checkOutput({tag, ":busyB"},  32'(busyB), 32'd0);
    checkOutput({tag, ":idOkB"},  32'(idOkB), 32'(expOkB));
    checkOutput({tag, ":toB"},    32'(toB),   32'(expToB));
    checkOutput({tag, ":sysIdB"}, sysIdB, expIdB);
    checkOutput({tag, ":sysTsB"}, sysTsB, expTsB);
    checkOutput({tag, ":readsB"}, 32'(acceptsB.size()), 32'(expReadsB));
    for (int i = 0; i < acceptsB.size() && i < 2; i++)
      checkOutput({tag, ":addrB"}, 32'(acceptsB[i]), 32'(i));
  endtask

  task automatic runCheck(input string tag, input bit viaReset,
                          input logic [31:0] iA, input logic [31:0] tA, input int siA, input int stA,
                          input logic [31:0] iB, input logic [31:0] tB, input int siB, input int stB,
                          output int latA);
    applyStimulus(viaReset, iA, tA, siA, stA, iB, tB, siB, stB);
    waitDone(latA);
    verifyAll(tag);
    repeat (4) @(negedge clock);
    verifyAll({tag, "-held"});
  endtask

  task automatic waitRdTsA(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (ifA.avm_read && ifA.avm_address) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ":readA"}, 32'(ifA.avm_read), 32'd0);
    checkOutput({tag, ":addrA"}, 32'(ifA.avm_address), 32'd0);
    checkOutput({tag, ":flagsA"}, 32'({busyA, doneA, idOkA, toA}), 32'd0);
    checkOutput({tag, ":sysIdA"}, sysIdA, 32'd0);
    checkOutput({tag, ":sysTsA"}, sysTsA, 32'd0);
    checkOutput({tag, ":readB"}, 32'(ifB.avm_read), 32'd0);
    checkOutput({tag, ":addrB"}, 32'(ifB.avm_address), 32'd0);
    checkOutput({tag, ":flagsB"}, 32'({busyB, doneB, idOkB, toB}), 32'd0);
    checkOutput({tag, ":sysIdB"}, sysIdB, 32'd0);
    checkOutput({tag, ":sysTsB"}, sysTsB, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] rIA, rTA, rIB, rTB;
    assertCount = 0;
    failCount   = 0;
    reset = 1'b1;
    start = 1'b0;
    idWordA = EXP_ID; tsWordA = EXP_TS; idWordB = EXP_ID; tsWordB = EXP_TS;
    stallIdA = 0; stallTsA = 0; stallIdB = 0; stallTsB = 0;

    $display("[TB] reset state");
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkAllZero("reset");

    $display("[TB] automatic check after reset, zero-wait slave");
    runCheck("auto", 1'b1, EXP_ID, EXP_TS, 0, 0, EXP_ID, EXP_TS, 0, 0, lat);
    checkOutput("autoLatency", 32'(lat >= 0 && lat <= 6), 32'd1);
    checkOutput("autoIdOkA", 32'(idOkA), 32'd1);

    $display("[TB] wrong ID word");
    runCheck("badId", 1'b0, 32'h0400_0001, EXP_TS, 0, 0, 32'h0400_0001, EXP_TS, 0, 0, lat);
    checkOutput("badIdSysA", sysIdA, 32'h0400_0001);
    checkOutput("badIdOkA", 32'(idOkA), 32'd0);

    $display("[TB] timestamp mismatch, checked vs ignored");
    runCheck("badTs", 1'b0, EXP_ID, EXP_TS ^ 32'd1, 0, 0, EXP_ID, EXP_TS + 32'd5, 0, 0, lat);
    checkOutput("badTsOkA", 32'(idOkA), 32'd0);
    checkOutput("badTsOkB", 32'(idOkB), 32'd1);

    $display("[TB] five wait states on each read");
    runCheck("wait5", 1'b0, EXP_ID, EXP_TS, 5, 5, EXP_ID, EXP_TS, 5, 5, lat);
    checkOutput("wait5OkA", 32'(idOkA), 32'd1);

    $display("[TB] permanent waitrequest on the short-timeout instance");
    runCheck("stuck", 1'b1, EXP_ID, EXP_TS, 0, 0, EXP_ID, EXP_TS, 1000, 1000, lat);
    checkOutput("stuckToB", 32'(toB), 32'd1);
    checkOutput("stuckSysIdB", sysIdB, 32'd0);

    $display("[TB] timeout boundary on the timestamp read");
    runCheck("stall7", 1'b0, EXP_ID, EXP_TS, 3, 2, EXP_ID, EXP_TS, 7, 7, lat);
    runCheck("stall8", 1'b0, EXP_ID, EXP_TS, 2, 3, 32'h0400_0007, EXP_TS, 0, TO_B, lat);

    $display("[TB] start while busy is ignored");
    applyStimulus(1'b0, EXP_ID, EXP_TS, 0, 6, EXP_ID, EXP_TS, 0, 6);
    waitRdTsA("reachRdTs");
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    waitDone(lat);
    verifyAll("busyStart");
    repeat (5) @(negedge clock);
    verifyAll("busyStart-held");

    $display("[TB] reset during the timestamp read");
    applyStimulus(1'b0, EXP_ID, EXP_TS, 1, 5, EXP_ID, EXP_TS, 1, 5);
    waitRdTsA("reachRdTsRst");
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkAllZero("midReset");
    @(posedge clock); #1 reset = 1'b0;
    acceptsA.delete();
    acceptsB.delete();
    waitDone(lat);
    verifyAll("rerun");
    checkOutput("rerunOkA", 32'(idOkA), 32'd1);

    $display("[TB] randomized checks");
    for (int n = 0; n < 16; n++) begin
      rIA = ($urandom_range(0, 2) == 0) ? (EXP_ID ^ (32'd1 << $urandom_range(0, 31))) : EXP_ID;
      rTA = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
      rIB = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
      rTB = ($urandom_range(0, 1) == 0) ? $urandom : EXP_TS;
      runCheck("rand", 1'b0, rIA, rTA, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               rIB, rTB, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h04000000, meaning the system ID value that must be read from sysid address 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'd1415959147, meaning the build timestamp value that must be read from sysid address 1.
REQ-003 SHALL have parameter CHECK_TS, default 1, meaning a timestamp mismatch fails the check when 1 and is ignored when 0.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the maximum cycles allowed per read transaction (range 1..65535).
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clock, input, 1 bit: system clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port start, input, 1 bit: one-cycle pulse requesting a re-check.
REQ-009 SHALL have port avm_address, output, 1 bit: Avalon-MM read address (0 = ID, 1 = timestamp).
REQ-010 SHALL have port avm_read, output, 1 bit: Avalon-MM read strobe.
REQ-011 SHALL have port avm_waitrequest, input, 1 bit: slave stall; the read is accepted in the cycle where avm_read=1 and avm_waitrequest=0.
REQ-012 SHALL have port avm_readdata, input, 32 bits: read data; sampled in the acceptance cycle (fixed latency 0).
REQ-013 SHALL have port busy, output, 1 bit: a check is in progress.
REQ-014 SHALL have port done, output, 1 bit: the last check has finished; held until the next check starts.
REQ-015 SHALL have port id_ok, output, 1 bit: the last check passed; valid while done=1.
REQ-016 SHALL have port timeout, output, 1 bit: the last check aborted on timeout; valid while done=1.
REQ-017 SHALL have port sys_id, output, 32 bits: captured ID word.
REQ-018 SHALL have port sys_ts, output, 32 bits: captured timestamp word.

Function
REQ-019 SHALL implement the states IDLE, RD_ID, RD_TS and FIN.
REQ-020 SHALL enter RD_ID in the first cycle after reset deasserts, performing an automatic check without a start pulse.
REQ-021 SHALL drive avm_read=1 and avm_address=0 in RD_ID, and hold both stable until acceptance.
REQ-022 SHALL, on acceptance in RD_ID, capture avm_readdata into sys_id and go to RD_TS.
REQ-023 SHALL drive avm_read=1 and avm_address=1 in RD_TS, and hold both stable until acceptance.
REQ-024 SHALL, on acceptance in RD_TS, capture avm_readdata into sys_ts and go to FIN.
REQ-025 SHALL deassert avm_read in the cycle after acceptance; there are no back-to-back strobes across states.
REQ-026 SHALL use a 16-bit wait counter that clears on entry to each read state and increments each cycle with avm_waitrequest=1.
REQ-027 SHALL go to FIN with timeout=1 and id_ok=0 when the wait counter reaches TIMEOUT_CYCLES, leaving the un-read capture register unchanged.
REQ-028 SHALL, in FIN, set id_ok = (sys_id==EXPECTED_ID) && (!CHECK_TS || sys_ts==EXPECTED_TS) && !timeout, and go to IDLE the next cycle.
REQ-029 SHALL assert done=1 from IDLE entry after FIN until the next check starts, and assert busy=1 in RD_ID, RD_TS and FIN.
REQ-030 SHALL, on start=1 in IDLE, clear done, id_ok and timeout and enter RD_ID on the next cycle.
REQ-031 SHALL ignore start while busy=1, with no queuing.
REQ-032 SHALL never change id_ok, timeout, sys_id or sys_ts while done=1, except on a new start or reset.

Reset
REQ-033 SHALL, on reset, force state IDLE with avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, timeout=0, sys_id=0 and sys_ts=0 on the following edge.
REQ-034 SHALL, if reset is asserted mid-read, drop avm_read in the next cycle, discard partial results, and restart the automatic check after release.

Verification
REQ-035 Zero-wait slave returning 0x04000000 and 1415959147 -> two reads at addresses 0 then 1, done=1, id_ok=1, timeout=0, all within 6 cycles of reset release.
REQ-036 Slave returning ID 0x04000001 -> done=1, id_ok=0, sys_id=0x04000001.
REQ-037 Timestamp mismatch with CHECK_TS=0 -> id_ok=1; same stimulus with CHECK_TS=1 -> id_ok=0.
REQ-038 waitrequest held for 5 cycles on each read -> address and read stable throughout, id_ok=1; waitrequest held permanently with TIMEOUT_CYCLES=8 -> timeout=1, id_ok=0, sys_id=0.
REQ-039 start pulsed during RD_TS -> ignored; start pulsed in IDLE -> done drops, a new two-read sequence runs.
REQ-040 reset asserted during RD_TS -> all outputs 0 next cycle; after release a full check reruns and id_ok=1.
